// File: rtl/ahb_mux_pkg.sv
// Shared encodings for the AHB-Lite slave response multiplexer.
// Transfer types, response codes and the data-phase FSM states.
package ahb_mux_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    NORM = 2'b00,
    ERR1 = 2'b01,
    ERR2 = 2'b10
  } state_t;

endpackage

// File: rtl/ahb_mux_onehot_enc.sv
// One-hot select to index encoder with exactly-one and multi-hit flags.
// Purely combinational.
module ahb_mux_onehot_enc #(
  parameter int NUM_SLAVES = 8,
  parameter int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [NUM_SLAVES-1:0] i_sel,
  output logic [IW-1:0]         o_idx,
  output logic                  o_valid,
  output logic                  o_multi
);

  logic w_any;
  logic w_single;

  assign w_any    = |i_sel;
  assign w_single = ((i_sel & (i_sel - 1'b1)) == '0);
  assign o_valid  = w_any & w_single;
  assign o_multi  = w_any & ~w_single;

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (i_sel[i]) o_idx = IW'(i);
    end
  end

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB-Lite slave response mux with default error slave and stall watchdog.
// Outputs depend only on registered select/state and slave responses.
import ahb_mux_pkg::*;

module ahb_slave_mux #(
  parameter int NUM_SLAVES     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [NUM_SLAVES-1:0]            HSEL,
  input  logic [1:0]                       HTRANS,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]            HRESP_S,
  input  logic                             TIMEOUT_CLR,
  output logic                             HREADY,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic                             HRESP,
  output logic                             TIMEOUT_FLAG,
  output logic [IW-1:0]                    TIMEOUT_IDX
);

  localparam int CW0 = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW  = (CW0 > 0) ? CW0 : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic            w_valid;
  logic            w_multi;
  logic [IW-1:0]   w_idx;
  logic            w_cap;
  logic            w_cap_err;
  logic            w_timeout;
  logic            w_s_ready;
  logic            w_s_resp;
  logic [DATA_WIDTH-1:0] w_s_data;

  state_t          r_state;
  state_t          w_next;
  logic            r_sel_valid;
  logic [IW-1:0]   r_sel_idx;
  logic            r_act;
  logic [CW-1:0]   r_stall_cnt;

  ahb_mux_onehot_enc #(
    .NUM_SLAVES(NUM_SLAVES),
    .IW        (IW)
  ) u_enc (
    .i_sel  (HSEL),
    .o_idx  (w_idx),
    .o_valid(w_valid),
    .o_multi(w_multi)
  );

  assign w_cap     = HREADY;
  assign w_cap_err = HTRANS[1] & (w_multi | ~|HSEL);

  assign w_s_ready = HREADYOUT_S[r_sel_idx];
  assign w_s_resp  = HRESP_S[r_sel_idx];
  assign w_s_data  = HRDATA_S[r_sel_idx*DATA_WIDTH +: DATA_WIDTH];

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == NORM) &&
                     r_sel_valid && !w_s_ready &&
                     (r_stall_cnt == CNT_LAST);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sel_valid <= 1'b0;
      r_sel_idx   <= '0;
      r_act       <= 1'b0;
    end else if (w_cap) begin
      r_sel_valid <= w_valid;
      r_sel_idx   <= w_valid ? w_idx : '0;
      r_act       <= HTRANS[1];
    end
  end

  // Saturating stall counter; only runs while a real slave holds the bus.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_stall_cnt <= '0;
    end else if ((r_state == NORM) && r_sel_valid && !w_s_ready &&
                 !w_timeout) begin
      if (r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + 1'b1;
    end else begin
      r_stall_cnt <= '0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      TIMEOUT_FLAG <= 1'b0;
      TIMEOUT_IDX  <= '0;
    end else if (w_timeout) begin
      TIMEOUT_FLAG <= 1'b1;
      TIMEOUT_IDX  <= r_sel_idx;
    end else if (TIMEOUT_CLR) begin
      TIMEOUT_FLAG <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= NORM;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      NORM: begin
        if (w_timeout)              w_next = ERR1;
        else if (w_cap && w_cap_err) w_next = ERR1;
      end
      ERR1:    w_next = ERR2;
      ERR2:    w_next = w_cap_err ? ERR1 : NORM;
      default: w_next = NORM;
    endcase
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    HRDATA = '0;
    unique case (r_state)
      NORM: begin
        if (r_sel_valid) begin
          HREADY = w_s_ready;
          HRESP  = w_s_resp;
          HRDATA = w_s_data;
        end else if (r_act) begin
          HRESP  = HRESP_ERROR;
        end
      end
      ERR1: begin
        HREADY = 1'b0;
        HRESP  = HRESP_ERROR;
      end
      ERR2:    HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

endmodule

// File: doc/ahb_slave_mux.md
# ahb_slave_mux

Parametrised AHB-Lite slave-side response multiplexer with a built-in default slave and a stall watchdog. It sits between the address decoder and the bus master. It registers the decoder's one-hot select in the address phase and routes the selected slave's HRDATA/HREADYOUT/HRESP back during the data phase. Unmapped or multi-hit addresses get a two-cycle AHB ERROR response. A slave that holds HREADYOUT low for too long is abandoned with an ERROR response and reported through a sticky flag.

## Interface
- NUM_SLAVES, 8: number of slave ports, 1..16.
- DATA_WIDTH, 32: HRDATA width.
- TIMEOUT_CYCLES, 256: consecutive stall cycles before abort; 0 disables the watchdog.
- Clocking: one clock; reset is asynchronous and active-low.
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  NUM_SLAVES  one-hot decoder select, address phase.
- HTRANS  in  2  master transfer type, address phase.
- HRDATA_S  in  NUM_SLAVES*DATA_WIDTH  slave read data, slice i = slave i.
- HREADYOUT_S  in  NUM_SLAVES  slave ready outputs.
- HRESP_S  in  NUM_SLAVES  slave responses, 1 = ERROR.
- TIMEOUT_CLR  in  1  clears TIMEOUT_FLAG, single-cycle pulse.
- HREADY  out  1  muxed ready to master and all slaves.
- HRDATA  out  DATA_WIDTH  muxed read data.
- HRESP  out  1  muxed response.
- TIMEOUT_FLAG  out  1  sticky: a watchdog abort has occurred.
- TIMEOUT_IDX  out  max(1,$clog2(NUM_SLAVES))  slave index of the last abort.

## Operation
- Address-phase capture on rising HCLK when HREADY=1:
  - sel_valid = exactly one HSEL bit set; sel_idx = that bit's index.
  - Zero or multiple bits set selects the default slave.
  - act = HTRANS[1], i.e. NONSEQ or SEQ.
  - While HREADY=0 the captured values hold.
- FSM states: NORM, ERR1, ERR2.
- NORM with a slave selected: HREADY = HREADYOUT_S[idx], HRESP = HRESP_S[idx], HRDATA = slice idx.
- NORM with default selected and act=0: HREADY=1, HRESP=0, HRDATA=0 (zero-wait OKAY).
- Default selected with act=1: NORM→ERR1 at the capture edge.
- ERR1 drives HREADY=0, HRESP=1, HRDATA=0; it always moves to ERR2.
- ERR2 drives HREADY=1, HRESP=1, HRDATA=0. The next address phase is captured at its end; ERR2→ERR1 if that phase is again an active default transfer, else ERR2→NORM.
- Watchdog, NORM with a slave selected:
  - stall_cnt increments each cycle HREADYOUT_S[idx]=0 and clears when it is 1 or on a new capture.
  - When stall_cnt reaches TIMEOUT_CYCLES-1 and the slave is still low, the next state is ERR1.
  - On that transition TIMEOUT_FLAG←1 and TIMEOUT_IDX←idx.
  - The slave is ignored from then on. Recovering it is software's job.
- Counter width is $clog2(TIMEOUT_CYCLES+1) and saturates; it never wraps.
- TIMEOUT_CLR in the same cycle as a new abort: the set wins.
- Reset values: sel = default, act=0, state NORM, stall_cnt=0, HREADY=1, HRESP=0, HRDATA=0, TIMEOUT_FLAG=0, TIMEOUT_IDX=0.
- Reset asserted mid-ERR1, mid-ERR2 or mid-stall returns to the reset values immediately, asynchronously.

## Timing
- Outputs are combinational from the registered select/state plus slave inputs. There is no added latency; a zero-wait slave completes in 1 data-phase cycle.
- Default-slave error: exactly 2 data-phase cycles (HREADY 0 then 1, HRESP 1 in both).
- Watchdog abort: after TIMEOUT_CYCLES stalled cycles, ERR1 is the next cycle and ERR2 the one after. Total data phase = TIMEOUT_CYCLES+2 cycles.
- No path from HSEL or HTRANS to any output.

## Structure
- Package ahb_mux_pkg:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
  - HRESP_OKAY/HRESP_ERROR.
  - FSM state enum {NORM, ERR1, ERR2}.
- Sub-module ahb_mux_onehot_enc: one-hot vector → index, valid (exactly-one), multi flag. Purely combinational, parametrised by NUM_SLAVES.
- Top holds the capture registers, FSM, watchdog counter and output mux.

## Test plan
- Reset, then NONSEQ to slave 3 with HRDATA_S3=0xA5A5_0003 and HREADYOUT_S3=1 → next cycle HRDATA=0xA5A5_0003, HREADY=1, HRESP=0.
- Slave 2 inserts 3 wait states → HREADY=0 for 3 cycles then 1. Select stays on slave 2 even if HSEL changes meanwhile.
- NONSEQ with HSEL=0, then HSEL=0b0101 back-to-back → two consecutive ERR1/ERR2 pairs (HREADY 0,1,0,1; HRESP 1 in all four cycles), HRDATA=0.
- IDLE transfer with HSEL=0 → single cycle HREADY=1, HRESP=0.
- TIMEOUT_CYCLES=16, slave 5 holds HREADYOUT=0 → after 16 stalled cycles, ERR1 then ERR2 follow, TIMEOUT_FLAG=1 and TIMEOUT_IDX=5. A TIMEOUT_CLR pulse clears the flag, but not in a cycle where a new abort sets it.
- HRESETn asserted during ERR1 → HREADY=1, HRESP=0, FSM NORM immediately, with no HCLK edge needed.
